led7_scan: RTL
==============

LED7_SCAN -- requirements
Module: led7_scan

Interface
REQ-001 Parameter DIV, default 50000: clock cycles per digit slot (1 kHz slot rate at 50 MHz).
REQ-002 Parameter BLANK, default 16: cycles at the start of each slot with all anodes off.
REQ-003 Port clk_i, input, 1: single clock; all state SHALL be clocked on its rising edge.
REQ-004 Port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-005 Port dig0_i..dig3_i, input, 8 each: segment patterns, active-low, bit7=a .. bit1=g, bit0=dp.
REQ-006 Port dig_en_i, input, 4: per-digit enable, bit n=1 shows digit n.
REQ-007 Port load_i, input, 1: single-cycle strobe; samples dig0_i..dig3_i and dig_en_i.
REQ-008 Port load_ack_o, output, 1: one-cycle pulse when sampled data becomes the displayed data.
REQ-009 Port frame_o, output, 1: one-cycle pulse at the start of each digit-0 slot.
REQ-010 Port led7_seg_o, output, 8: segment drive, active-low, same bit order as dig*_i.
REQ-011 Port led7_an_o, output, 4: anode drive, active-low, bit n = digit n.

Function
REQ-012 Slot counter cnt SHALL count 0..DIV-1 and wrap to 0; digit index idx SHALL advance 0->1->2->3->0 on each wrap.
REQ-013 While cnt < BLANK, led7_an_o SHALL be 4'b1111 and led7_seg_o SHALL be 8'hFF.
REQ-014 While cnt >= BLANK, led7_seg_o SHALL be active[idx]; led7_an_o SHALL have only bit idx low if en[idx]=1, else 4'b1111.
REQ-015 led7_seg_o, led7_an_o and frame_o SHALL be registered, with exactly 1 cycle latency from the (cnt, idx) state that selects them.
REQ-016 frame_o SHALL pulse when the outputs first reflect idx=0, cnt=0.
REQ-017 On load_i=1, the block SHALL copy the inputs into a shadow register and set pending=1.
REQ-018 A load_i while pending=1 SHALL overwrite the shadow; only one load_ack_o SHALL follow.
REQ-019 The shadow SHALL transfer to active/en on the frame-boundary cycle (cnt=DIV-1, idx=3) if pending=1; pending SHALL clear and load_ack_o SHALL pulse in the next cycle.
REQ-020 If load_i coincides with the frame-boundary cycle, the newly sampled inputs SHALL be transferred directly (bypassing the old shadow), followed by one load_ack_o.
REQ-021 Displayed data SHALL never change mid-frame (no tearing).
REQ-022 Parameter legality: BLANK>=1 and DIV>=BLANK+2; violations SHALL fail elaboration.

Reset
REQ-023 On rst_ni=0, cnt=0, idx=0, active=8'hFF x4, en=4'b0000, shadow=8'hFF x4, pending=0.
REQ-024 During and after reset, led7_an_o=4'b1111, led7_seg_o=8'hFF, load_ack_o=0, frame_o=0.
REQ-025 A load pending at reset assertion SHALL be discarded with no load_ack_o.
REQ-026 Reset deassertion SHALL start scanning at idx=0 with a blank interval, then frame_o in the first cycle after release.

Structure
REQ-027 Package led7_pkg SHALL hold SEG_W=8, DIGITS=4, SEG_OFF=8'hFF, AN_OFF=4'hF and glyph constants: GLYPH_0=8'h03, GLYPH_E=8'h61, GLYPH_BLANK=8'hFF.
REQ-028 One sub-module led7_tick SHALL implement the DIV prescaler, producing cnt, a wrap strobe and idx; double buffering and output registers SHALL stay in led7_scan.

Verification (DIV=8, BLANK=2)
REQ-029 Reset, then load dig0..3=03,61,FF,03 with en=1111 -> first frame all dark; from frame 2, an cycles 1110,1101,1011,0111 with seg 03,61,FF,03 for cycles 2..7 of each slot and 1111/FF for cycles 0..1.
REQ-030 en=0101 -> digits 1 and 3 keep an=1111 for the whole slot; digits 0 and 2 scan normally.
REQ-031 Three load_i pulses in one frame with distinct data -> one load_ack_o at the boundary; the last data is displayed.
REQ-032 load_i exactly on cycle cnt=7, idx=3 -> new data appears in the next digit-0 slot; load_ack_o pulses once.
REQ-033 Assert rst_ni mid-slot with pending=1 -> outputs go 1111/FF asynchronously; no ack; after release, frame_o pulses and the display stays dark until a new load.
REQ-034 Run 10 frames -> frame_o period is exactly 32 cycles, and no cycle has more than one anode low.

Source files
------------

// File: rtl/led7_pkg.sv
// Shared constants, glyphs and helpers for the multiplexed 7-segment scanner.
package led7_pkg;

  localparam int SEG_W  = 8;
  localparam int DIGITS = 4;
  localparam int IDX_W  = $clog2(DIGITS);

  // Segment and anode lines are active-low: all ones means dark.
  localparam logic [SEG_W-1:0]  SEG_OFF = 8'hFF;
  localparam logic [DIGITS-1:0] AN_OFF  = 4'hF;

  // Segment order is a..g, dp from bit 7 down to bit 0.
  localparam logic [SEG_W-1:0] GLYPH_0     = 8'h03;
  localparam logic [SEG_W-1:0] GLYPH_E     = 8'h61;
  localparam logic [SEG_W-1:0] GLYPH_BLANK = 8'hFF;

  // Width needed to hold a count of 0..div-1 (at least one bit).
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  // Active-low one-hot anode pattern selecting a single digit.
  function automatic logic [DIGITS-1:0] an_select(input logic [IDX_W-1:0] idx);
    logic [DIGITS-1:0] an;
    an      = AN_OFF;
    an[idx] = 1'b0;
    return an;
  endfunction

endpackage

// File: rtl/led7_tick.sv
// Slot prescaler: counts clock cycles within a digit slot and steps the
// digit index each time the slot count wraps.
module led7_tick
  import led7_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int CNT_W = cnt_width(DIV)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic [IDX_W-1:0] idx
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("led7_tick: DIV must be at least 2");
  end

  assign wrap = (cnt == CNT_LAST);

  // Slot counter and digit index; the index only moves on a slot wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
      idx <= '0;
    end else if (wrap) begin
      cnt <= '0;
      idx <= idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led7_scan.sv
// Four-digit multiplexed 7-segment driver with a double-buffered display
// image. New data is staged in a shadow copy and only swapped in at the
// frame boundary, so a frame is always drawn from one consistent image.
module led7_scan
  import led7_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int BLANK = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [SEG_W-1:0] dig0_i,
  input  logic [SEG_W-1:0] dig1_i,
  input  logic [SEG_W-1:0] dig2_i,
  input  logic [SEG_W-1:0] dig3_i,
  input  logic [DIGITS-1:0] dig_en_i,
  input  logic             load_i,
  output logic             load_ack_o,
  output logic             frame_o,
  output logic [SEG_W-1:0] led7_seg_o,
  output logic [DIGITS-1:0] led7_an_o
);

  localparam int CNT_W = cnt_width(DIV);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  // Blanking needs at least one dark cycle and at least one lit cycle
  // per slot on top of the wrap cycle.
  if (BLANK < 1 || DIV < BLANK + 2) begin : g_bad_params
    $error("led7_scan: requires BLANK >= 1 and DIV >= BLANK + 2");
  end

  logic [CNT_W-1:0]  cnt_p0;
  logic [IDX_W-1:0]  idx_p0;
  logic              wrap_p0;
  logic              boundary_p0;

  logic [SEG_W-1:0]  dig_in   [DIGITS];
  logic [SEG_W-1:0]  shadow   [DIGITS];
  logic [DIGITS-1:0] shadow_en;
  logic [SEG_W-1:0]  active   [DIGITS];
  logic [DIGITS-1:0] active_en;
  logic              pending;

  logic [SEG_W-1:0]  seg_p1;
  logic [DIGITS-1:0] an_p1;
  logic              frame_p1;
  logic              ack_p1;

  led7_tick #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_tick (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .cnt    (cnt_p0),
    .wrap   (wrap_p0),
    .idx    (idx_p0)
  );

  // Last cycle of the last digit slot: the only point where the image swaps.
  assign boundary_p0 = wrap_p0 && (idx_p0 == IDX_LAST);

  // Gather the per-digit inputs into an array for indexed copies.
  always_comb begin
    dig_in[0] = dig0_i;
    dig_in[1] = dig1_i;
    dig_in[2] = dig2_i;
    dig_in[3] = dig3_i;
  end

  // Stage p0 -> p1: shadow capture, boundary swap and load acknowledge.
  // A load landing on the boundary itself goes straight to the active image
  // so it is not delayed by a whole frame; the older shadow is dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DIGITS; i++) begin
        shadow[i] <= GLYPH_BLANK;
        active[i] <= GLYPH_BLANK;
      end
      shadow_en <= '0;
      active_en <= '0;
      pending   <= 1'b0;
      ack_p1    <= 1'b0;
    end else begin
      ack_p1 <= 1'b0;
      if (load_i) begin
        for (int i = 0; i < DIGITS; i++) shadow[i] <= dig_in[i];
        shadow_en <= dig_en_i;
      end
      if (boundary_p0 && (load_i || pending)) begin
        if (load_i) begin
          for (int i = 0; i < DIGITS; i++) active[i] <= dig_in[i];
          active_en <= dig_en_i;
        end else begin
          for (int i = 0; i < DIGITS; i++) active[i] <= shadow[i];
          active_en <= shadow_en;
        end
        pending <= 1'b0;
        ack_p1  <= 1'b1;
      end else if (load_i) begin
        pending <= 1'b1;
      end
    end
  end

  // Stage p0 -> p1: registered segment/anode drive and frame marker.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seg_p1   <= SEG_OFF;
      an_p1    <= AN_OFF;
      frame_p1 <= 1'b0;
    end else begin
      frame_p1 <= (cnt_p0 == '0) && (idx_p0 == '0);
      if (cnt_p0 < CNT_BLANK) begin
        seg_p1 <= SEG_OFF;
        an_p1  <= AN_OFF;
      end else begin
        seg_p1 <= active[idx_p0];
        an_p1  <= active_en[idx_p0] ? an_select(idx_p0) : AN_OFF;
      end
    end
  end

  assign led7_seg_o = seg_p1;
  assign led7_an_o  = an_p1;
  assign frame_o    = frame_p1;
  assign load_ack_o = ack_p1;

endmodule
